// File: rtl/barramento_sel.sv
// ---------------------------------------------------------------------------
// barramento_sel
//
// Registered bus-source selector for the simple processor datapath. One of
// NREG general registers, DIN or G is placed on the shared bus and
// registered. The block also reports which source drove the bus and detects
// and counts cycles in which more than one source strobe was raised.
//
// Optional feature macro: BARRAMENTO_CONFLICT_CHECK_EN
//   defined     -> sticky conflict flag and saturating conflict counter
//   not defined -> o_conflict / o_conflict_cnt tied to 0, i_clr_conflict
//                  ignored; selection behaviour is identical
//
// Ports:
//   i_clock         rising-edge clock
//   i_reset         asynchronous active-high reset
//   i_r_bus         packed registers, R_i at [i*N +: N]
//   i_din           external data input
//   i_g             ALU result register
//   i_rout          register select strobes (one-hot expected)
//   i_gout          G select strobe
//   i_dinout        DIN select strobe
//   i_en            capture enable
//   i_clr_conflict  synchronous clear of conflict flag and counter
//   o_bus_wires     registered bus value
//   o_bus_valid     high for the cycle after a capture that had a source
//   o_src_id        source code: 0..NREG-1 = R_i, 16 = DIN, 17 = G, 31 = none
//   o_conflict      sticky multi-source flag
//   o_conflict_cnt  saturating count of conflicting capture cycles
//
// Handshake: there is no back-pressure. A capture happens on every edge
// where i_en is high; o_bus_valid qualifies o_bus_wires for exactly one
// cycle after a capture that had at least one strobe raised.
// ---------------------------------------------------------------------------
module barramento_sel #(
    parameter int N     = 16,
    parameter int NREG  = 8,
    parameter int CNT_W = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NREG*N-1:0] i_r_bus,
    input  logic [N-1:0]      i_din,
    input  logic [N-1:0]      i_g,
    input  logic [NREG-1:0]   i_rout,
    input  logic              i_gout,
    input  logic              i_dinout,
    input  logic              i_en,
    input  logic              i_clr_conflict,
    output logic [N-1:0]      o_bus_wires,
    output logic              o_bus_valid,
    output logic [4:0]        o_src_id,
    output logic              o_conflict,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    localparam logic [4:0] SRC_DIN  = 5'd16;
    localparam logic [4:0] SRC_G    = 5'd17;
    localparam logic [4:0] SRC_NONE = 5'd31;

    logic [N-1:0] w_sel_val;
    logic [4:0]   w_sel_id;
    logic         w_any;

    logic [N-1:0] r_bus_wires;
    logic         r_bus_valid;
    logic [4:0]   r_src_id;

    // Priority G > DIN > lowest-index Rout. The register loop runs from the
    // top index down so the lowest set bit is the last (winning) assignment.
    always_comb begin
        w_sel_val = '0;
        w_sel_id  = SRC_NONE;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (i_rout[i]) begin
                w_sel_val = i_r_bus[i*N +: N];
                w_sel_id  = 5'(i);
            end
        end
        if (i_dinout) begin
            w_sel_val = i_din;
            w_sel_id  = SRC_DIN;
        end
        if (i_gout) begin
            w_sel_val = i_g;
            w_sel_id  = SRC_G;
        end
        w_any = (|i_rout) | i_gout | i_dinout;
    end

    // With no strobe the bus value is held; only src_id moves to "none".
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bus_wires <= '0;
            r_bus_valid <= 1'b0;
            r_src_id    <= SRC_NONE;
        end else begin
            r_bus_valid <= 1'b0;
            if (i_en) begin
                r_src_id <= w_sel_id;
                if (w_any) begin
                    r_bus_wires <= w_sel_val;
                    r_bus_valid <= 1'b1;
                end
            end
        end
    end

    assign o_bus_wires = r_bus_wires;
    assign o_bus_valid = r_bus_valid;
    assign o_src_id    = r_src_id;

`ifdef BARRAMENTO_CONFLICT_CHECK_EN
    logic             w_rout_multi;
    logic             w_multi;
    logic             w_conf_now;
    logic [CNT_W-1:0] w_cnt_base;
    logic             r_conflict;
    logic [CNT_W-1:0] r_conflict_cnt;

    // x & (x-1) is non-zero exactly when two or more Rout bits are set.
    assign w_rout_multi = |(i_rout & (i_rout - NREG'(1)));
    assign w_multi      = w_rout_multi | (i_gout & i_dinout)
                        | ((i_gout | i_dinout) & (|i_rout));
    assign w_conf_now   = i_en & w_multi;
    // The clear is applied first, then this cycle's conflict event on top.
    assign w_cnt_base   = i_clr_conflict ? '0 : r_conflict_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_conflict     <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_conflict <= w_conf_now | (r_conflict & ~i_clr_conflict);
            if (w_conf_now && !(&w_cnt_base)) begin
                r_conflict_cnt <= w_cnt_base + CNT_W'(1);
            end else begin
                r_conflict_cnt <= w_cnt_base;
            end
        end
    end

    assign o_conflict     = r_conflict;
    assign o_conflict_cnt = r_conflict_cnt;
`else
    logic w_unused_clr;
    assign w_unused_clr   = i_clr_conflict;
    assign o_conflict     = 1'b0;
    assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_barramento_sel.sv
module tb_barramento_sel;

    localparam int N     = 16;
    localparam int NREG  = 8;
    localparam int CNT_W = 8;

`ifdef BARRAMENTO_CONFLICT_CHECK_EN
    localparam bit CC = 1'b1;
`else
    localparam bit CC = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [NREG*N-1:0] r_bus;
    logic [N-1:0]      din;
    logic [N-1:0]      g;
    logic [NREG-1:0]   rout;
    logic              gout;
    logic              dinout;
    logic              en;
    logic              clr;
    logic [N-1:0]      bus_wires;
    logic              bus_valid;
    logic [4:0]        src_id;
    logic              conflict;
    logic [CNT_W-1:0]  conflict_cnt;

    int checks   = 0;
    int failures = 0;

    barramento_sel #(.N(N), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_r_bus        (r_bus),
        .i_din          (din),
        .i_g            (g),
        .i_rout         (rout),
        .i_gout         (gout),
        .i_dinout       (dinout),
        .i_en           (en),
        .i_clr_conflict (clr),
        .o_bus_wires    (bus_wires),
        .o_bus_valid    (bus_valid),
        .o_src_id       (src_id),
        .o_conflict     (conflict),
        .o_conflict_cnt (conflict_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NREG-1:0]  rout;
        logic             gout;
        logic             dinout;
        logic             en;
        logic             clr;
        logic [N-1:0]     e_bus;
        logic             e_valid;
        logic [4:0]       e_src;
        logic             e_conf;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic ec(input logic v);
        return CC ? v : 1'b0;
    endfunction

    function automatic logic [CNT_W-1:0] ecnt(input int v);
        return CC ? CNT_W'(v) : '0;
    endfunction

    task automatic add(input logic [NREG-1:0] ro, input logic go, input logic dio,
                       input logic e, input logic c, input logic [N-1:0] eb,
                       input logic ev, input logic [4:0] es, input logic ecf,
                       input int en_cnt);
        vec_t v;
        v.rout = ro; v.gout = go; v.dinout = dio; v.en = e; v.clr = c;
        v.e_bus = eb; v.e_valid = ev; v.e_src = es;
        v.e_conf = ec(ecf); v.e_cnt = ecnt(en_cnt);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] eb, input logic ev,
                             input logic [4:0] es, input logic ecf,
                             input logic [CNT_W-1:0] ecn);
        check({tag, ".bus"},   32'(bus_wires),    32'(eb));
        check({tag, ".valid"}, 32'(bus_valid),    32'(ev));
        check({tag, ".src"},   32'(src_id),       32'(es));
        check({tag, ".conf"},  32'(conflict),     32'(ecf));
        check({tag, ".cnt"},   32'(conflict_cnt), 32'(ecn));
    endtask

    // drive, take one edge, sample 1 ns later
    task automatic drive(input logic [NREG-1:0] ro, input logic go, input logic dio,
                         input logic e, input logic c);
        rout = ro; gout = go; dinout = dio; en = e; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // register contents: R_i = 0xC000 + i, except R_3 = 0xBEEF
        for (int i = 0; i < NREG; i++) r_bus[i*N +: N] = 16'hC000 + 16'(i);
        r_bus[3*N +: N] = 16'hBEEF;
        din = 16'h5678; g = 16'h1234;
        rout = '0; gout = 0; dinout = 0; en = 0; clr = 0;

        // reset block
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 16'h0000, 1'b0, 5'd31, 1'b0, '0);
        rst = 1'b0;
        @(negedge clk);

        // directed table; each row is one edge starting from reset state
        add(8'b00001000, 0, 0, 1, 0, 16'hBEEF, 1, 5'd3,  0, 0);
        add(8'b00000000, 0, 0, 1, 0, 16'hBEEF, 0, 5'd31, 0, 0);
        add(8'b00100000, 1, 1, 1, 0, 16'h1234, 1, 5'd17, 1, 1);
        add(8'b00100000, 0, 1, 1, 0, 16'h5678, 1, 5'd16, 1, 2);
        add(8'b00100000, 0, 0, 1, 0, 16'hC005, 1, 5'd5,  1, 2);
        add(8'b00000110, 0, 0, 1, 0, 16'hC001, 1, 5'd1,  1, 3);
        add(8'b00000001, 1, 0, 0, 0, 16'hC001, 0, 5'd1,  1, 3);
        add(8'b00000000, 0, 0, 1, 1, 16'hC001, 0, 5'd31, 0, 0);
        add(8'b00000000, 1, 0, 1, 0, 16'h1234, 1, 5'd17, 0, 0);
        add(8'b10000000, 0, 0, 1, 0, 16'hC007, 1, 5'd7,  0, 0);
        add(8'b00000000, 0, 1, 1, 0, 16'h5678, 1, 5'd16, 0, 0);
        add(8'b01000000, 0, 0, 1, 0, 16'hC006, 1, 5'd6,  0, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].rout, vecs[k].gout, vecs[k].dinout, vecs[k].en, vecs[k].clr);
            check_all($sformatf("vec%0d", k), vecs[k].e_bus, vecs[k].e_valid,
                      vecs[k].e_src, vecs[k].e_conf, vecs[k].e_cnt);
        end

        // en=0 hold: BusWires=0x1111 then strobes ignored
        din = 16'h1111;
        drive('0, 0, 1, 1, 0);
        check_all("load1111", 16'h1111, 1'b1, 5'd16, 1'b0, '0);
        din = 16'h5678;
        r_bus[0 +: N] = 16'hAAAA;
        drive(8'b00000001, 0, 0, 0, 0);
        check_all("hold1", 16'h1111, 1'b0, 5'd16, 1'b0, '0);
        drive(8'b00010001, 1, 1, 0, 0);
        check_all("hold_multi", 16'h1111, 1'b0, 5'd16, 1'b0, '0);
        drive(8'b00000001, 0, 0, 1, 0);
        check_all("r0_after_hold", 16'hAAAA, 1'b1, 5'd0, 1'b0, '0);

        // saturation: 300 consecutive conflicting captures
        for (int k = 1; k <= 300; k++) begin
            drive(8'b00000001, 1, 1, 1, 0);
            check($sformatf("sat%0d.cnt", k), 32'(conflict_cnt), 32'(ecnt(k > 255 ? 255 : k)));
        end
        check("sat.conf", 32'(conflict), 32'(ec(1'b1)));
        check("sat.bus",  32'(bus_wires), 32'h1234);
        // clear together with a conflict
        drive(8'b00000011, 0, 0, 1, 1);
        check_all("clr_conf", 16'hAAAA, 1'b1, 5'd0, ec(1'b1), ecnt(1));
        // clear alone
        drive('0, 0, 0, 1, 1);
        check_all("clr_alone", 16'hAAAA, 1'b0, 5'd31, 1'b0, '0);
        idle();

        // async reset mid-capture, checked before the next edge
        drive(8'b00000000, 1, 1, 1, 0);
        rout = 8'b00001000; en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all("mid_reset", 16'h0000, 1'b0, 5'd31, 1'b0, '0);
        @(posedge clk);
        #1;
        check_all("held_reset", 16'h0000, 1'b0, 5'd31, 1'b0, '0);
        rst = 1'b0;
        drive(8'b00001000, 0, 0, 1, 0);
        check_all("post_reset", 16'hBEEF, 1'b1, 5'd3, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barramento_sel.md
# barramento_sel

Parametrised, registered bus-source selector for the simple processor datapath. It selects one of NREG general registers, the DIN input or the G (ALU result) register onto the shared bus and registers the result. It reports which source was driven and detects and counts illegal multi-source selections. It sits between the register file/ALU outputs and every bus consumer (registers, A, G, address/data out), and is driven by the control FSM's Rout/Gout/DINout strobes.

## Interface
Parameters:
- N, 16, bus and register width in bits (4..32)
- NREG, 8, number of general registers (2..16)
- CNT_W, 8, width of the conflict counter

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- R_bus  in  NREG*N  packed registers; R_i at bits [i*N +: N]
- DIN  in  N  external data input
- G  in  N  ALU result register
- Rout  in  NREG  register select strobes, one-hot expected
- Gout  in  1  G select strobe
- DINout  in  1  DIN select strobe
- en  in  1  capture enable
- clr_conflict  in  1  synchronous clear of conflict flag and counter
- BusWires  out  N  registered bus value
- bus_valid  out  1  high for the cycle after a capture that had a source
- src_id  out  5  source of current BusWires: 0..NREG-1 = R_i, 16 = DIN, 17 = G, 31 = none
- conflict  out  1  sticky: a multi-source select was seen
- conflict_cnt  out  CNT_W  saturating count of conflicting capture cycles

## Operation
- Reset (async, any time, including mid-capture): BusWires=0, bus_valid=0, src_id=31, conflict=0, conflict_cnt=0.
- Fixed priority: Gout > DINout > lowest-index set Rout bit.
- en=1 and at least one strobe set: BusWires <= selected value, src_id <= its code, bus_valid <= 1.
- en=1, no strobe set: BusWires holds its previous value (no latch, no zeroing), src_id <= 31, bus_valid <= 0.
- en=0: BusWires, src_id, conflict and conflict_cnt hold; bus_valid <= 0; strobes ignored.
- Conflict: en=1 and more than one of {Rout bits, Gout, DINout} set. The cycle still captures per priority. conflict <= 1. conflict_cnt increments and saturates at 2^CNT_W-1, never wrapping.
- clr_conflict: the clear applies first, then the current cycle's event. If clr_conflict and a conflict occur in the same cycle, conflict=1 and conflict_cnt=1 afterwards. If clr_conflict occurs alone, both go to 0.
- Rout bits at index ≥ NREG do not exist. src_id codes 18..30 are never produced.

## Timing
- Latency 1 cycle: strobes and data sampled at edge k appear on BusWires/src_id/bus_valid after edge k.
- No combinational path from any input to any output.
- Back-to-back captures are allowed every cycle with no bubble.
- conflict and conflict_cnt update on the same edge as the offending capture.

## Configuration
- BARRAMENTO_CONFLICT_CHECK_EN defined: conflict detection, the sticky flag and the counter are built as described above.
- Not defined: conflict and conflict_cnt are tied to 0. clr_conflict is ignored. Priority selection and all other behaviour are unchanged.

## Test plan
- Reset with N=16, NREG=8 → BusWires=0x0000, src_id=31, bus_valid=0, conflict=0, conflict_cnt=0; assert Reset mid-capture → same values immediately, before the next edge.
- R_3=0xBEEF, Rout=8'b00001000, en=1 for one cycle → after next edge BusWires=0xBEEF, src_id=3, bus_valid=1; following idle cycle → BusWires=0xBEEF, src_id=31, bus_valid=0.
- G=0x1234, DIN=0x5678, Gout=1, DINout=1, Rout=8'b00100000 → BusWires=0x1234, src_id=17, conflict=1, conflict_cnt=1; then DINout+Rout[5] → BusWires=0x5678, src_id=16, conflict_cnt=2.
- 300 consecutive conflicting captures with CNT_W=8 → conflict_cnt stops at 255; clr_conflict together with a conflict → conflict=1, conflict_cnt=1; clr_conflict alone → conflict=0, conflict_cnt=0.
- en=0 with Rout=8'b00000001 and R_0=0xAAAA while BusWires=0x1111 → BusWires stays 0x1111, bus_valid=0, conflict_cnt unchanged, also with multiple strobes set.
- Build without BARRAMENTO_CONFLICT_CHECK_EN, repeat the conflict stimulus → same BusWires/src_id as above, conflict=0, conflict_cnt=0.
